// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI initiator.
// Holds the controller FSM state enum, the fixed SPI mode (mode 0, MSB
// first) and the default word width, which matches the GPU configuration word.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_HOLD     = 3'd4,
        ST_GAP      = 3'd5
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic msb_first;
    } spi_mode_t;

    // Mode 0: sclk idles low, data sampled on the rising edge, MSB first.
    localparam spi_mode_t SPI_MODE = '{cpol: 1'b0, cpha: 1'b0, msb_first: 1'b1};

    // One GPU configuration word per frame.
    localparam int SPI_WORD_BITS = 32;

    // sclk level for an active (high) or idle phase, derived from CPOL.
    function automatic logic spi_sclk_level(input logic active);
        return active ? ~SPI_MODE.cpol : SPI_MODE.cpol;
    endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// spi_clk_tick: phase timer for the SPI controller.
// A CLK_DIV down-counter that is reloaded on every FSM state change and
// raises `tick` in the last cycle of each phase. With CLK_DIV=1 every
// cycle is a phase end.
module spi_clk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_r;

    // Count down through the current phase; restart on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (reload) begin
            cnt_r <= LOAD_VAL;
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI initiator, mode 0, MSB first.
// Shifts a WORD_BITS word out on mosi framed by ss, generating sclk with
// CLK_DIV clk cycles per half-period. Receive capture on miso is built only
// when SPI_CONTROLLER_RX_EN is defined; otherwise rx_data is constant 0 and
// transmit timing is unchanged.
// Frame: IDLE -> SETUP -> (SHIFT_HI <-> SHIFT_LO) -> HOLD -> GAP -> IDLE,
// each timed phase lasting CLK_DIV cycles. All outputs come straight from
// flops that are loaded with the values belonging to the next state.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int WORD_BITS = SPI_WORD_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WORD_BITS-1:0] tx_data,
    input  logic                 miso,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_BITS-1:0] rx_data,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 ss
);

    localparam int BW = $clog2(WORD_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);

    spi_state_e           state_r;
    spi_state_e           state_next_s;
    logic [WORD_BITS-1:0] tx_sr_r;
    logic [WORD_BITS-1:0] tx_sr_next_s;
    logic [BW-1:0]        bit_cnt_r;
    logic [BW-1:0]        bit_cnt_next_s;
    logic                 tick_s;
    logic                 reload_s;

    logic ss_r, sclk_r, mosi_r, busy_r, done_r;
    logic ss_next_s, sclk_next_s, mosi_next_s, busy_next_s, done_next_s;

    spi_clk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .reload (reload_s),
        .tick   (tick_s)
    );

    // Every transition changes state, so a state change is the reload point
    assign reload_s = (state_next_s != state_r);

    // State, transmit shift register and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            tx_sr_r   <= {WORD_BITS{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
        end else begin
            state_r   <= state_next_s;
            tx_sr_r   <= tx_sr_next_s;
            bit_cnt_r <= bit_cnt_next_s;
        end
    end

    // Next-state logic: phase sequencing, word latch and bit shifting
    always_comb begin
        state_next_s   = state_r;
        tx_sr_next_s   = tx_sr_r;
        bit_cnt_next_s = bit_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s   = ST_SETUP;
                    tx_sr_next_s   = tx_data;
                    bit_cnt_next_s = {BW{1'b0}};
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (tick_s) begin
                    state_next_s = ST_SHIFT_HI;
                end else begin
                    state_next_s = ST_SETUP;
                end
            end
            ST_SHIFT_HI: begin
                if (tick_s && (bit_cnt_r == LAST_BIT)) begin
                    state_next_s = ST_HOLD;
                end else if (tick_s) begin
                    // Falling edge: present the next lower bit right away
                    state_next_s = ST_SHIFT_LO;
                    tx_sr_next_s = {tx_sr_r[WORD_BITS-2:0], 1'b0};
                end else begin
                    state_next_s = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_LO: begin
                if (tick_s) begin
                    state_next_s   = ST_SHIFT_HI;
                    bit_cnt_next_s = bit_cnt_r + BW'(1);
                end else begin
                    state_next_s = ST_SHIFT_LO;
                end
            end
            ST_HOLD: begin
                if (tick_s) begin
                    state_next_s = ST_GAP;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (tick_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the state being entered; registered below
    always_comb begin
        ss_next_s   = 1'b1;
        sclk_next_s = spi_sclk_level(1'b0);
        mosi_next_s = 1'b0;
        busy_next_s = 1'b1;
        done_next_s = (state_r == ST_HOLD) && (state_next_s == ST_GAP);
        case (state_next_s)
            ST_IDLE: begin
                busy_next_s = 1'b0;
            end
            ST_SETUP, ST_SHIFT_LO, ST_HOLD: begin
                ss_next_s   = 1'b0;
                mosi_next_s = tx_sr_next_s[WORD_BITS-1];
            end
            ST_SHIFT_HI: begin
                ss_next_s   = 1'b0;
                sclk_next_s = spi_sclk_level(1'b1);
                mosi_next_s = tx_sr_next_s[WORD_BITS-1];
            end
            ST_GAP: begin
                ss_next_s = 1'b1;
            end
            default: begin
                busy_next_s = 1'b0;
            end
        endcase
    end

    // Output flops, so no input reaches an output combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_r   <= 1'b1;
            sclk_r <= 1'b0;
            mosi_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            ss_r   <= ss_next_s;
            sclk_r <= sclk_next_s;
            mosi_r <= mosi_next_s;
            busy_r <= busy_next_s;
            done_r <= done_next_s;
        end
    end

    assign ss   = ss_r;
    assign sclk = sclk_r;
    assign mosi = mosi_r;
    assign busy = busy_r;
    assign done = done_r;

`ifdef SPI_CONTROLLER_RX_EN
    logic                 entry_r;
    logic [WORD_BITS-1:0] rx_sr_r;
    logic [WORD_BITS-1:0] rx_data_r;

    // Mark the first cycle of every state (the cycle sclk rises in SHIFT_HI)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_r <= 1'b0;
        end else begin
            entry_r <= reload_s;
        end
    end

    // Shift miso in MSB first on the rising-edge cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr_r <= {WORD_BITS{1'b0}};
        end else if ((state_r == ST_SHIFT_HI) && entry_r) begin
            rx_sr_r <= {rx_sr_r[WORD_BITS-2:0], miso};
        end else begin
            rx_sr_r <= rx_sr_r;
        end
    end

    // Publish the received word together with the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_r <= {WORD_BITS{1'b0}};
        end else if (done_next_s) begin
            rx_data_r <= rx_sr_r;
        end else begin
            rx_data_r <= rx_data_r;
        end
    end

    assign rx_data = rx_data_r;
`else
    // Receive path not built: miso is deliberately ignored.
    logic unused_miso_s;
    assign unused_miso_s = miso;
    assign rx_data       = {WORD_BITS{1'b0}};
`endif

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: scoreboard bench for spi_controller.
// DUT A (CLK_DIV=2, WORD_BITS=32) runs directed and random frames with miso
// looped back from mosi (or tied high); a monitor decodes mosi at each rising
// sclk edge, measures ss/busy/done timing and retires scoreboard entries.
// DUT B (CLK_DIV=1, WORD_BITS=8) covers the minimum divider.
module tb_spi_controller;

    localparam int DA = 2;
    localparam int WA = 32;
    localparam int DB = 1;
    localparam int WB = 8;

    // Frame timing from the protocol description
    localparam int SS_LOW_A = DA * (1 + 2 * WA);
    localparam int BUSY_A   = SS_LOW_A + DA;
    // ss high between held-start frames: GAP phase plus the IDLE accept cycle
    localparam int GAP_A    = DA + 1;
    localparam int SS_LOW_B = DB * (1 + 2 * WB);
    localparam int BUSY_B   = SS_LOW_B + DB;

`ifdef SPI_CONTROLLER_RX_EN
    localparam logic [WA-1:0] RX_MASK = {WA{1'b1}};
`else
    localparam logic [WA-1:0] RX_MASK = {WA{1'b0}};
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic          start_a    = 1'b0;
    logic [WA-1:0] tx_a       = '0;
    logic          miso_ovr_a = 1'b0;
    logic          miso_a, busy_a, done_a, sclk_a, mosi_a, ss_a;
    logic [WA-1:0] rx_a;

    logic          start_b = 1'b0;
    logic [WB-1:0] tx_b    = '0;
    logic          miso_b, busy_b, done_b, sclk_b, mosi_b, ss_b;
    logic [WB-1:0] rx_b;

    assign miso_a = miso_ovr_a ? 1'b1 : mosi_a;
    assign miso_b = mosi_b;

    spi_controller #(.CLK_DIV(DA), .WORD_BITS(WA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_a), .miso(miso_a),
        .busy(busy_a), .done(done_a), .rx_data(rx_a), .sclk(sclk_a), .mosi(mosi_a), .ss(ss_a)
    );

    spi_controller #(.CLK_DIV(DB), .WORD_BITS(WB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_b), .miso(miso_b),
        .busy(busy_b), .done(done_b), .rx_data(rx_b), .sclk(sclk_b), .mosi(mosi_b), .ss(ss_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WA-1:0] word;
        logic [WA-1:0] rx;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec      = 0;
    int   n_err      = 0;
    int   frames_exp = 0;
    int   done_cnt   = 0;
    int   edges_a    = 0;
    int   last_gap_a = 0;

    task automatic check(input string name, input logic [WA-1:0] act, input logic [WA-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the sent word comes back over loopback, all ones if miso is tied high
    function automatic logic [WA-1:0] model_rx(input logic [WA-1:0] word, input logic tied_hi);
        return (tied_hi ? {WA{1'b1}} : word) & RX_MASK;
    endfunction

    // Drive one cycle of DUT A inputs; record an expectation when start will be accepted
    task automatic step(input logic s, input logic [WA-1:0] d);
        exp_t e;
        @(negedge clk);
        start_a = s;
        tx_a    = d;
        if (s && !busy_a && rst_n) begin
            e.word = d;
            e.rx   = model_rx(d, miso_ovr_a);
            exp_q.push_back(e);
            frames_exp++;
        end
    endtask

    // Idle DUT A until every expected frame has retired, within a cycle budget
    task automatic drain(input int budget);
        int n;
        n = 0;
        do begin
            step(1'b0, $urandom());
            n++;
        end while ((exp_q.size() != 0 || busy_a) && n < budget);
        check("drain_in_budget", (exp_q.size() == 0 && !busy_a), 1'b1);
    endtask

    // Monitor state for DUT A
    logic          ss_prev = 1'b1, sclk_prev = 1'b0, busy_prev = 1'b0, done_prev = 1'b0;
    logic          in_frame = 1'b0;
    int            ss_low = 0, gap_cnt = 0, busy_run = 0;
    logic [WA-1:0] bits = '0;

    // Measure DUT A frames and retire scoreboard entries when ss is released
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ss_prev = 1'b1; sclk_prev = 1'b0; busy_prev = 1'b0; done_prev = 1'b0;
            in_frame = 1'b0; ss_low = 0; gap_cnt = 0; busy_run = 0; edges_a = 0;
        end else begin
            if (done_prev) check("done_width", done_a, 1'b0);
            if (done_a) done_cnt++;
            if (ss_prev && !ss_a) begin
                last_gap_a = gap_cnt;
                in_frame   = 1'b1;
                ss_low     = 0;
                edges_a    = 0;
                bits       = '0;
            end
            if (!ss_prev && ss_a && in_frame) begin
                in_frame = 1'b0;
                gap_cnt  = 0;
                check("done_at_ss_release", done_a, 1'b1);
                check("frame_expected", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("ss_low_cycles", ss_low, SS_LOW_A);
                    check("rising_edges", edges_a, WA);
                    check("mosi_decoded", bits, e.word);
                    check("rx_data", rx_a, e.rx);
                end
            end
            if (!ss_a) begin
                ss_low++;
                if (!sclk_prev && sclk_a) begin
                    edges_a++;
                    bits = {bits[WA-2:0], mosi_a};
                end
            end else begin
                gap_cnt++;
            end
            if (busy_a) begin
                busy_run++;
            end else if (busy_prev) begin
                check("busy_cycles", busy_run, BUSY_A);
                busy_run = 0;
            end
            ss_prev   = ss_a;
            sclk_prev = sclk_a;
            busy_prev = busy_a;
            done_prev = done_a;
        end
    end

    // Minimum-divider frame on DUT B with tx 0x80 and miso looped back
    task automatic run_b();
        int            n_low, n_busy, n_edges, n_bad, n_done;
        logic          fell, sclk_p;
        logic [WB-1:0] dec;
        logic [WA-1:0] d;
        n_low = 0; n_busy = 0; n_edges = 0; n_bad = 0; n_done = 0;
        fell = 1'b0; sclk_p = 1'b0; dec = '0; d = 32'h0000_0080;
        @(negedge clk);
        start_b = 1'b1;
        tx_b    = d[WB-1:0];
        for (int i = 0; i < 3 * BUSY_B; i++) begin
            @(negedge clk);
            start_b = 1'b0;
            tx_b    = 8'h00;
            if (busy_b) n_busy++;
            if (done_b) n_done++;
            if (!ss_b) begin
                n_low++;
                if (sclk_p && !sclk_b) fell = 1'b1;
                if (!sclk_p && sclk_b) begin
                    n_edges++;
                    dec = {dec[WB-2:0], mosi_b};
                end
                if (mosi_b !== !fell) n_bad++;
            end
            sclk_p = sclk_b;
        end
        check("b_ss_low_cycles", n_low, SS_LOW_B);
        check("b_busy_cycles", n_busy, BUSY_B);
        check("b_rising_edges", n_edges, WB);
        check("b_mosi_decoded", dec, d);
        check("b_mosi_high_until_first_fall", n_bad, 0);
        check("b_done_pulses", n_done, 1);
        check("b_rx_data", rx_b, model_rx(d, 1'b0) & 32'h0000_00FF);
    endtask

    initial begin
        int            saved_done, n;
        logic [WA-1:0] w;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ss",   ss_a,   1'b1);
        check("rst_sclk", sclk_a, 1'b0);
        check("rst_mosi", mosi_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_rx",   rx_a,   '0);
        check("rst_b_ss", ss_b,   1'b1);
        check("rst_b_rx", rx_b,   '0);
        rst_n = 1'b1;

        // Idle with start low: the bus stays quiet
        for (int i = 0; i < 100; i++) begin
            step(1'b0, $urandom());
            check("idle_ss", ss_a, 1'b1);
            check("idle_sclk", sclk_a, 1'b0);
        end

        // Single loopback frame
        step(1'b1, 32'hA5C3_0F81);
        drain(400);

        // miso tied high: rx reflects the tie only when receive logic exists
        miso_ovr_a = 1'b1;
        step(1'b1, 32'h1234_5678);
        drain(400);
        miso_ovr_a = 1'b0;

        // Minimum divider
        run_b();

        // start held high; tx_data changes mid-frame and must not affect it
        for (int i = 0; i < 40; i++) step(1'b1, 32'h0000_00FF);
        for (int i = 0; i < 160; i++) step(1'b1, 32'hFFFF_FF00);
        drain(400);
        check("b2b_ss_high_gap", last_gap_a, GAP_A);

        // Random traffic, including start pulses while busy
        for (int i = 0; i < 3000; i++) step(($urandom_range(0, 15) == 0), $urandom());
        drain(400);

        // Reset after the 10th rising edge aborts the frame
        w = $urandom();
        step(1'b1, w);
        n = 0;
        do begin
            step(1'b0, $urandom());
            n++;
        end while (edges_a < 10 && n < 300);
        check("reached_tenth_edge", (edges_a >= 10), 1'b1);
        saved_done = done_cnt;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ss_async", ss_a, 1'b1);
        check("abort_sclk_async", sclk_a, 1'b0);
        exp_q.delete();
        frames_exp--;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, $urandom());
        check("abort_no_done", done_cnt, saved_done);

        // Fresh frame after reset
        step(1'b1, $urandom());
        drain(400);

        check("done_count", done_cnt, frames_exp);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
